// File: rtl/fir_out_quantize.sv
// FIR accumulator output stage: fill-sample discard, round half-up, saturate,
// and a small output FIFO with valid/ready read side.
module fir_out_quantize #(
  parameter int unsigned ACC_WIDTH    = 48,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned FRAC_SHIFT   = 16,
  parameter int unsigned FILL_LAT     = 5,
  parameter bit          UNSIGNED_OUT = 1'b0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CE,
  input  logic [ACC_WIDTH-1:0] P_IN,
  input  logic                 P_VALID,
  input  logic                 FLUSH,
  output logic [OUT_WIDTH-1:0] Y,
  output logic                 Y_VALID,
  input  logic                 Y_READY,
  output logic [15:0]          SAT_CNT,
  output logic                 DROP
);

  localparam int unsigned CNT_W = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(1) << (FRAC_SHIFT - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic {S_FILL, S_RUN} state_t;
  localparam state_t ST_INIT = (FILL_LAT == 0) ? S_RUN : S_FILL;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [ACC_WIDTH:0]     r1_q, r1_d;
  logic                   v1_q, v1_d;
  logic [OUT_WIDTH-1:0]   y2_q, y2_d;
  logic                   sat2_q, sat2_d;
  logic                   v2_q, v2_d;
  logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic [15:0]            sat_cnt_q, sat_cnt_d;
  logic                   drop_q, drop_d;

  logic                   accept, empty, full, pop, wr, push;
  logic signed [ACC_WIDTH:0] q_s;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    r1_d       = r1_q;
    v1_d       = v1_q;
    y2_d       = y2_q;
    sat2_d     = sat2_q;
    v2_d       = v2_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_d      = mem_q;
    sat_cnt_d  = sat_cnt_q;
    drop_d     = drop_q;

    accept = CE & P_VALID;
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop    = ~empty & Y_READY;
    wr     = CE & v2_q;
    // A full FIFO still accepts the write when the same edge pops a slot free.
    push   = wr & (~full | pop);
    q_s    = $signed(r1_q) >>> FRAC_SHIFT;

    if (CE) begin
      if (state_q == S_FILL && accept) begin
        if (fill_cnt_q == CNT_W'(FILL_LAT - 1)) state_d = S_RUN;
        else fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
      // Extra headroom bit keeps the rounding add from wrapping at full scale.
      r1_d = {P_IN[ACC_WIDTH-1], P_IN} + RND;
      v1_d = accept && (state_q == S_RUN);
      v2_d = v1_q;
      y2_d   = q_s[OUT_WIDTH-1:0];
      sat2_d = 1'b0;
      if (UNSIGNED_OUT) begin
        if (q_s[ACC_WIDTH]) begin
          y2_d   = '0;
          sat2_d = 1'b1;
        end else if (|q_s[ACC_WIDTH-1:OUT_WIDTH]) begin
          y2_d   = '1;
          sat2_d = 1'b1;
        end
      end else if (!((&q_s[ACC_WIDTH:OUT_WIDTH-1]) || !(|q_s[ACC_WIDTH:OUT_WIDTH-1]))) begin
        y2_d   = q_s[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        sat2_d = 1'b1;
      end
    end

    if (push) begin
      mem_d[wptr_q[AW-1:0]] = y2_q;
      wptr_d = wptr_q + PTR_ONE;
      if (sat2_q && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
    end
    if (pop) rptr_d = rptr_q + PTR_ONE;
    if (wr && full && !pop) drop_d = 1'b1;

    if (FLUSH) begin
      v1_d       = 1'b0;
      v2_d       = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      fill_cnt_d = '0;
      sat_cnt_d  = '0;
      drop_d     = 1'b0;
      state_d    = ST_INIT;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_INIT;
      fill_cnt_q <= '0;
      r1_q       <= '0;
      v1_q       <= 1'b0;
      y2_q       <= '0;
      sat2_q     <= 1'b0;
      v2_q       <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      sat_cnt_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      r1_q       <= r1_d;
      v1_q       <= v1_d;
      y2_q       <= y2_d;
      sat2_q     <= sat2_d;
      v2_q       <= v2_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
      sat_cnt_q  <= sat_cnt_d;
      drop_q     <= drop_d;
    end
  end

  assign Y       = mem_q[rptr_q[AW-1:0]];
  assign Y_VALID = ~empty;
  assign SAT_CNT = sat_cnt_q;
  assign DROP    = drop_q;

endmodule

// File: tb/tb_fir_out_quantize.sv
// Scoreboard bench: stimulus pushes expected outputs, negedge monitors pop and compare.
module tb_fir_out_quantize;

  logic        CLK = 1'b0;
  logic        RST_N, CE, P_VALID, FLUSH, Y_READY;
  logic [47:0] P_IN;
  logic [15:0] Y, SAT_CNT;
  logic        Y_VALID, DROP;

  logic [47:0] u_p;
  logic        u_valid;
  logic [15:0] u_y, u_sat;
  logic        u_y_valid, u_drop;

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] expq [$];
  logic [15:0] uq [$];

  always #5 CLK = ~CLK;

  fir_out_quantize #(.ACC_WIDTH(48), .OUT_WIDTH(16), .FRAC_SHIFT(16), .FILL_LAT(5),
                     .UNSIGNED_OUT(1'b0), .FIFO_DEPTH(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .P_IN(P_IN), .P_VALID(P_VALID), .FLUSH(FLUSH),
    .Y(Y), .Y_VALID(Y_VALID), .Y_READY(Y_READY), .SAT_CNT(SAT_CNT), .DROP(DROP));

  fir_out_quantize #(.ACC_WIDTH(48), .OUT_WIDTH(16), .FRAC_SHIFT(16), .FILL_LAT(5),
                     .UNSIGNED_OUT(1'b1), .FIFO_DEPTH(4)) u_dut_uns (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .P_IN(u_p), .P_VALID(u_valid), .FLUSH(FLUSH),
    .Y(u_y), .Y_VALID(u_y_valid), .Y_READY(1'b1), .SAT_CNT(u_sat), .DROP(u_drop));

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (RST_N && Y_VALID && Y_READY) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL y_unexpected got=%h exp=none at %0t", Y, $time);
      end else begin
        check("y_main", {32'h0, Y}, {32'h0, expq.pop_front()});
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && u_y_valid) begin
      if (uq.size() == 0) begin
        n_total++;
        $display("FAIL y_uns_unexpected got=%h exp=none at %0t", u_y, $time);
      end else begin
        check("y_uns", {32'h0, u_y}, {32'h0, uq.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [47:0] p, input bit keep, input logic [15:0] exp);
    if (keep) expq.push_back(exp);
    P_IN = p;
    P_VALID = 1'b1;
    tick();
    P_VALID = 1'b0;
  endtask

  task automatic send_u(input logic [47:0] p, input bit keep, input logic [15:0] exp);
    if (keep) uq.push_back(exp);
    u_p = p;
    u_valid = 1'b1;
    tick();
    u_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (expq.size() == 0 && uq.size() == 0) break;
      tick();
    end
    check("drain_pending", 48'(expq.size() + uq.size()), 48'd0);
    tick();
  endtask

  initial begin
    RST_N = 1'b0; CE = 1'b1; P_VALID = 1'b0; FLUSH = 1'b0; Y_READY = 1'b1;
    P_IN = '0; u_p = '0; u_valid = 1'b0;
    tick();
    check("rst_y", {32'h0, Y}, 48'd0);
    check("rst_y_valid", {47'h0, Y_VALID}, 48'd0);
    check("rst_sat_cnt", {32'h0, SAT_CNT}, 48'd0);
    check("rst_drop", {47'h0, DROP}, 48'd0);
    RST_N = 1'b1;
    tick();

    // Fill: first five discarded, latency three edges from acceptance
    for (int k = 0; k < 10; k++) begin
      send(48'(k) << 16, k >= 5, 16'(k));
      if (k == 6) check("latency_not_yet", {47'h0, Y_VALID}, 48'd0);
      if (k == 7) check("latency_valid", {47'h0, Y_VALID}, 48'd1);
    end
    drain();

    // Rounding
    send(48'h000000008000, 1'b1, 16'h0001);
    send(48'h000000007FFF, 1'b1, 16'h0000);
    send(48'hFFFFFFFF8000, 1'b1, 16'h0000);
    send(48'hFFFFFFFF7FFF, 1'b1, 16'hFFFF);
    drain();
    check("round_sat_cnt", {32'h0, SAT_CNT}, 48'd0);

    // Saturation, including rounding carry into overflow
    send(48'h000080000000, 1'b1, 16'h7FFF);
    send(48'hFFFF00000000, 1'b1, 16'h8000);
    send(48'h00007FFF8000, 1'b1, 16'h7FFF);
    send(48'h00007FFF7FFF, 1'b1, 16'h7FFF);
    drain();
    check("sat_cnt_3", {32'h0, SAT_CNT}, 48'd3);

    // Unsigned clamp instance
    for (int k = 0; k < 5; k++) send_u(48'h000012340000, 1'b0, 16'h0);
    send_u(48'hFFFFFFFF0000, 1'b1, 16'h0000);
    send_u(48'h000100000000, 1'b1, 16'hFFFF);
    send_u(48'h0000ABCD0000, 1'b1, 16'hABCD);
    send_u(48'h000000008000, 1'b1, 16'h0001);
    drain();
    check("uns_sat_cnt", {32'h0, u_sat}, 48'd2);

    // Backpressure: four fit, two dropped
    Y_READY = 1'b0;
    for (int k = 1; k <= 6; k++) send(48'(8'h10 + k) << 16, k <= 4, 16'(8'h10 + k));
    repeat (3) tick();
    check("bp_y_valid", {47'h0, Y_VALID}, 48'd1);
    check("bp_drop", {47'h0, DROP}, 48'd1);
    Y_READY = 1'b1;
    drain();
    check("bp_empty", {47'h0, Y_VALID}, 48'd0);

    // Flush with three in FIFO and two in the pipeline
    Y_READY = 1'b0;
    for (int k = 1; k <= 5; k++) send(48'(8'h60 + k) << 16, 1'b0, 16'h0);
    check("pre_flush_valid", {47'h0, Y_VALID}, 48'd1);
    check("pre_flush_sat", {32'h0, SAT_CNT}, 48'd3);
    FLUSH = 1'b1;
    send(48'h006F0000, 1'b0, 16'h0);
    FLUSH = 1'b0;
    check("flush_y_valid", {47'h0, Y_VALID}, 48'd0);
    check("flush_sat_cnt", {32'h0, SAT_CNT}, 48'd0);
    check("flush_drop", {47'h0, DROP}, 48'd0);
    Y_READY = 1'b1;
    for (int k = 1; k <= 6; k++) send(48'(8'h50 + k) << 16, k == 6, 16'(8'h50 + k));
    drain();

    // Clock-enable pause: pipeline frozen, FIFO still drains
    Y_READY = 1'b0;
    for (int k = 1; k <= 4; k++) send(48'(8'h20 + k) << 16, 1'b1, 16'(8'h20 + k));
    CE = 1'b0; P_VALID = 1'b1; P_IN = 48'h00990000; Y_READY = 1'b1;
    repeat (3) tick();
    check("ce_pause_drained", {47'h0, Y_VALID}, 48'd0);
    CE = 1'b1; P_VALID = 1'b0;
    for (int k = 5; k <= 8; k++) send(48'(8'h20 + k) << 16, 1'b1, 16'(8'h20 + k));
    drain();

    // Asynchronous reset mid-stream
    Y_READY = 1'b0;
    send(48'h00310000, 1'b0, 16'h0);
    send(48'h00320000, 1'b0, 16'h0);
    send(48'h000080000000, 1'b0, 16'h0);
    send(48'h00340000, 1'b0, 16'h0);
    send(48'h00350000, 1'b0, 16'h0);
    repeat (3) tick();
    check("pre_rst_y", {32'h0, Y}, 48'h31);
    check("pre_rst_sat", {32'h0, SAT_CNT}, 48'd1);
    check("pre_rst_drop", {47'h0, DROP}, 48'd1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_y", {32'h0, Y}, 48'd0);
    check("arst_y_valid", {47'h0, Y_VALID}, 48'd0);
    check("arst_sat_cnt", {32'h0, SAT_CNT}, 48'd0);
    check("arst_drop", {47'h0, DROP}, 48'd0);
    tick();
    RST_N = 1'b1;
    Y_READY = 1'b1;
    for (int k = 1; k <= 6; k++) send(48'(8'h40 + k) << 16, k == 6, 16'(8'h40 + k));
    drain();
    check("uns_drop", {47'h0, u_drop}, 48'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
